tetris_drop_timer: RTL and testbench
====================================

# tetris_drop_timer

Gravity timer for the Tetris core. It sits downstream of the power-on startup delay and holds the game idle until the delay's `starting` level asserts. It then emits one-cycle `drop_tick` pulses at a level-dependent period, which the piece controller uses to move the active piece down one row. It also supports pause, soft drop, game-over halt and restart.

## Interface
- `BASE_PERIOD`, default 25_000_000: drop period in clk cycles at level 0 (0.5 s at 50 MHz).
- `LEVEL_STEP`, default 2_000_000: cycles removed from the period per level.
- `MIN_PERIOD`, default 2_500_000: floor on the level-derived period; must be ≥ 2.
- `SOFT_PERIOD`, default 2_500_000: period ceiling while soft drop is held; must be ≥ 2.
- `CNT_W`, default 25: counter width; must hold `BASE_PERIOD`.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `starting  in  1`: level from the startup delay; high means power-on delay done.
- `pause_tgl  in  1`: one-cycle pulse that toggles pause.
- `soft_drop  in  1`: level; accelerates drops while high.
- `level  in  4`: current game level, 0..15.
- `game_over  in  1`: level; stops ticking.
- `restart  in  1`: one-cycle pulse; returns to waiting for start.
- `drop_tick  out  1`: one-cycle registered drop pulse.
- `running  out  1`: high in RUN.
- `paused  out  1`: high in PAUSED.
- `state  out  2`: encoded state, for debug.

## Operation
- States and encodings: WAIT_START=0, RUN=1, PAUSED=2, HALTED=3.
- Period selection, combinational and evaluated every cycle:
  - `p_lvl = max(BASE_PERIOD − level·LEVEL_STEP, MIN_PERIOD)`.
  - Compute the subtraction signed or guarded so it cannot underflow.
  - `period = soft_drop ? min(p_lvl, SOFT_PERIOD) : p_lvl`.
- Transitions, evaluated in priority order:
  1. `restart`: from any state go to WAIT_START and clear `count`.
  2. `game_over` in RUN or PAUSED: go to HALTED.
  3. WAIT_START with `starting` high: go to RUN with `count = 0`.
  4. RUN with `pause_tgl`: go to PAUSED.
  5. PAUSED with `pause_tgl`: go to RUN.
- `pause_tgl` is ignored in WAIT_START and HALTED.
- HALTED is left only by `restart`.
- `starting` is sampled only in WAIT_START. A later drop of `starting` is ignored.
- Counter in RUN:
  - If `count ≥ period−1`: `count ← 0` and `drop_tick ← 1`.
  - Otherwise: `count ← count+1` and `drop_tick ← 0`.
- The `≥` comparison guarantees a tick on the next cycle when the period shrinks below the current count (level-up or soft-drop press).
- PAUSED holds `count`. HALTED and WAIT_START force `count = 0`.
- `drop_tick` is 0 in every state other than RUN. It is also 0 on the cycle a transition leaves RUN, because the transition takes priority over the tick.

## Timing
- Reset values:
  - state WAIT_START
  - `count` 0
  - `drop_tick` 0
  - `running` 0
  - `paused` 0
  - `state` 2'd0
- `running`, `paused` and `state` are decoded from the state register. They change on the clk edge that changes state.
- Start latency:
  - `starting` high at edge E moves the block to RUN at E+1.
  - The first `drop_tick` is high in cycle E+1+period.
  - Subsequent ticks are exactly `period` cycles apart while the period is constant.
- Pause/resume: the total cycles spent in RUN between two ticks equals `period`, with the PAUSED time excluded.
- Simultaneous `restart` and `game_over`: restart wins.
- Simultaneous `pause_tgl` and a tick boundary in RUN: go to PAUSED, no tick, and `count` is held at its value.
- Reset asserted mid-operation clears all outputs immediately (asynchronous).

## Structure
- A shared `tetris_pkg` holds:
  - the state encoding localparams
  - the default period constants, so the piece controller and the score/level logic agree on level semantics
- One sub-module is natural: `drop_period_calc`, the combinational period selection (level scaling, floor, soft-drop ceiling), reusable by the display for a speed indicator.
- The FSM and counter stay in the top module.

## Test plan
All scenarios use `BASE_PERIOD=20`, `LEVEL_STEP=4`, `MIN_PERIOD=4`, `SOFT_PERIOD=3`, `CNT_W=8`.
- **Start and period:** reset, then hold `starting` low for 10 cycles, then raise it, with level 0. Required: no tick while waiting, `running` high 1 cycle after `starting` is sampled, first tick 20 cycles later, then ticks every 20 cycles.
- **Level scaling and floor:** level=2 gives ticks every 12 cycles. Level=5 and level=15 both give ticks every 4 cycles (floor).
- **Soft drop mid-count:** at level 0 with `count=10`, assert `soft_drop`. Required: tick on the next cycle, then every 3 cycles. On release, the period returns to 20.
- **Pause:** pulse `pause_tgl` at `count=7` and wait 50 cycles. Required: `paused` high and no ticks. Pulse `pause_tgl` again: the tick arrives 13 cycles after resume.
- **Halt and restart:** assert `game_over` in RUN. Required: HALTED, ticks stop, and `pause_tgl` is ignored. Pulse `restart` together with `game_over`: WAIT_START. With `starting` still high: RUN on the next cycle.
- **Async reset mid-RUN:** drop `rst` between clk edges. Required: all outputs 0 and `state`=0 immediately.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared Tetris core definitions: drop-timer state encoding and default gravity constants.
package tetris_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned LEVEL_W = 4;

    typedef enum logic [STATE_W-1:0] {
        WAIT_START = 2'd0,
        RUN        = 2'd1,
        PAUSED     = 2'd2,
        HALTED     = 2'd3
    } drop_state_e;

    // Level semantics shared by the piece controller and score/level logic (50 MHz clock).
    localparam int unsigned DEF_BASE_PERIOD = 25_000_000;
    localparam int unsigned DEF_LEVEL_STEP  = 2_000_000;
    localparam int unsigned DEF_MIN_PERIOD  = 2_500_000;
    localparam int unsigned DEF_SOFT_PERIOD = 2_500_000;
    localparam int unsigned DEF_CNT_W       = 25;

endpackage

// File: rtl/drop_period_calc.sv
// Combinational drop period selection: level scaling, floor, and soft-drop ceiling.
module drop_period_calc
    import tetris_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned SOFT_PERIOD = DEF_SOFT_PERIOD,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               soft_drop_i,
    output logic [CNT_W-1:0]   period_c
);

    logic [31:0] dec_c;
    logic [31:0] lvl_c;
    logic [31:0] sel_c;

    // Guarded subtraction: fall back to the floor before the difference can wrap.
    always_comb begin
        dec_c = 32'(level_i) * LEVEL_STEP;
        if ((BASE_PERIOD > dec_c) && ((BASE_PERIOD - dec_c) > MIN_PERIOD)) begin
            lvl_c = BASE_PERIOD - dec_c;
        end else begin
            lvl_c = MIN_PERIOD;
        end
        sel_c = (soft_drop_i && (lvl_c > SOFT_PERIOD)) ? SOFT_PERIOD : lvl_c;
    end

    assign period_c = CNT_W'(sel_c);

endmodule

// File: rtl/tetris_drop_timer.sv
// Gravity timer: waits for startup, then emits level-paced drop ticks with pause, halt and restart.
module tetris_drop_timer
    import tetris_pkg::*;
#(
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned LEVEL_STEP  = DEF_LEVEL_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned SOFT_PERIOD = DEF_SOFT_PERIOD,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               starting,
    input  logic               pause_tgl,
    input  logic               soft_drop,
    input  logic [LEVEL_W-1:0] level,
    input  logic               game_over,
    input  logic               restart,
    output logic               drop_tick,
    output logic               running,
    output logic               paused,
    output logic [STATE_W-1:0] state
);

    drop_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] period_c;

    drop_period_calc #(
        .BASE_PERIOD (BASE_PERIOD),
        .LEVEL_STEP  (LEVEL_STEP),
        .MIN_PERIOD  (MIN_PERIOD),
        .SOFT_PERIOD (SOFT_PERIOD),
        .CNT_W       (CNT_W)
    ) u_period (
        .level_i     (level),
        .soft_drop_i (soft_drop),
        .period_c    (period_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT_START;
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Transitions outrank the tick; >= catches a period that shrank below the current count.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tick_d  = 1'b0;
        if (restart) begin
            state_d = WAIT_START;
            count_d = '0;
        end else if (game_over && ((state_q == RUN) || (state_q == PAUSED))) begin
            state_d = HALTED;
            count_d = '0;
        end else begin
            case (state_q)
                WAIT_START: begin
                    count_d = '0;
                    if (starting) state_d = RUN;
                end
                RUN: begin
                    if (pause_tgl) begin
                        state_d = PAUSED;
                    end else if (count_q >= (period_c - CNT_W'(1))) begin
                        count_d = '0;
                        tick_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                PAUSED: begin
                    if (pause_tgl) state_d = RUN;
                end
                HALTED: begin
                    count_d = '0;
                end
                default: begin
                    state_d = WAIT_START;
                    count_d = '0;
                end
            endcase
        end
    end

    assign drop_tick = tick_q;
    assign running   = (state_q == RUN);
    assign paused    = (state_q == PAUSED);
    assign state     = state_q;

endmodule

// File: tb/tb_tetris_drop_timer.sv
// Scoreboard bench for tetris_drop_timer: directed scenarios plus random stimulus against a cycle model.
module tb_tetris_drop_timer;
    import tetris_pkg::*;

    localparam int unsigned BP = 20;
    localparam int unsigned LS = 4;
    localparam int unsigned MP = 4;
    localparam int unsigned SP = 3;
    localparam int unsigned CW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       starting = 1'b0, pause_tgl = 1'b0, soft_drop = 1'b0;
    logic       game_over = 1'b0, restart = 1'b0;
    logic [3:0] level = 4'd0;
    logic       drop_tick, running, paused;
    logic [1:0] state;

    tetris_drop_timer #(
        .BASE_PERIOD (BP), .LEVEL_STEP (LS), .MIN_PERIOD (MP),
        .SOFT_PERIOD (SP), .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .starting  (starting),
        .pause_tgl (pause_tgl),
        .soft_drop (soft_drop),
        .level     (level),
        .game_over (game_over),
        .restart   (restart),
        .drop_tick (drop_tick),
        .running   (running),
        .paused    (paused),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic [1:0] st;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_tick = -1;
    int   interval = 0;
    int   n_ticks = 0;

    // Reference model: mode 0 wait, 1 run, 2 paused, 3 halted; since = run cycles since last tick.
    int   m_mode = 0;
    int   m_since = 0;

    bit   cur_st = 1'b0, cur_sd = 1'b0, cur_go = 1'b0;
    int   cur_lvl = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int model_period(input int lvl, input bit sd);
        int p;
        p = int'(BP) - lvl * int'(LS);
        if (p < int'(MP)) p = int'(MP);
        if (sd && p > int'(SP)) p = int'(SP);
        return p;
    endfunction

    // Drive one cycle of inputs, predict the post-edge outputs, then return just after that edge.
    task automatic step(input bit st, input bit pt, input bit sd, input int lvl, input bit go, input bit rs);
        bit tk;
        int p;
        tk = 1'b0;
        starting = st; pause_tgl = pt; soft_drop = sd; level = 4'(lvl);
        game_over = go; restart = rs;
        p = model_period(lvl, sd);
        if (rs) begin
            m_mode = 0; m_since = 0;
        end else if (go && (m_mode == 1 || m_mode == 2)) begin
            m_mode = 3; m_since = 0;
        end else if (m_mode == 0) begin
            if (st) m_mode = 1;
            m_since = 0;
        end else if (m_mode == 1 && pt) begin
            m_mode = 2;
        end else if (m_mode == 2 && pt) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            m_since++;
            if (m_since >= p) begin
                tk = 1'b1;
                m_since = 0;
            end
        end
        sb_q.push_back('{tick: tk, st: 2'(m_mode)});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_st, 1'b0, cur_sd, cur_lvl, cur_go, 1'b0);
    endtask

    task automatic pulse_pause();
        step(cur_st, 1'b1, cur_sd, cur_lvl, cur_go, 1'b0);
    endtask

    task automatic run_to_count(input int target, input string name);
        int k;
        k = 0;
        while (m_since != target && k < 60) begin
            idle(1);
            k++;
        end
        check(name, m_since, target);
    endtask

    // Monitor: pops one expectation per edge and tracks tick spacing.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (drop_tick === 1'b1) begin
            n_ticks++;
            if (last_tick >= 0) interval = cyc - last_tick;
            last_tick = cyc;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("drop_tick", int'(drop_tick), int'(e.tick));
            check("state", int'(state), int'(e.st));
            check("running", int'(running), int'(e.st == 2'd1));
            check("paused", int'(paused), int'(e.st == 2'd2));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_before;
        int resume_cyc;

        repeat (3) @(posedge clk);
        #2;
        check("rst_tick", int'(drop_tick), 0);
        check("rst_running", int'(running), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_state", int'(state), 0);
        rst = 1'b1;
        m_mode = 0; m_since = 0;

        // Start and base period.
        idle(10);
        check("wait_no_tick", n_ticks, 0);
        cur_st = 1'b1;
        idle(1);
        check("start_running", int'(running), 1);
        resume_cyc = cyc;
        idle(20);
        check("first_tick_latency", last_tick - resume_cyc, 20);
        idle(45);
        check("period_lvl0", interval, 20);

        // Level scaling and floor.
        cur_lvl = 2;  idle(40); check("period_lvl2", interval, 12);
        cur_lvl = 5;  idle(20); check("period_lvl5", interval, 4);
        cur_lvl = 15; idle(20); check("period_lvl15", interval, 4);

        // Soft drop pressed mid-count.
        cur_lvl = 0;
        idle(25);
        run_to_count(10, "reach_count10");
        cur_sd = 1'b1;
        idle(1);
        check("soft_immediate_tick", int'(drop_tick), 1);
        idle(12);
        check("period_soft", interval, 3);
        cur_sd = 1'b0;
        idle(45);
        check("period_soft_release", interval, 20);

        // Pause at count 7 and resume.
        run_to_count(7, "reach_count7");
        pulse_pause();
        check("paused_entered", int'(paused), 1);
        t_before = n_ticks;
        idle(50);
        check("paused_hold", int'(paused), 1);
        check("paused_no_ticks", n_ticks, t_before);
        pulse_pause();
        resume_cyc = cyc;
        idle(15);
        check("resume_latency", last_tick - resume_cyc, 13);

        // Halt, ignored pause, restart over game_over.
        cur_go = 1'b1;
        idle(1);
        check("halted", int'(state), 3);
        t_before = n_ticks;
        pulse_pause();
        idle(5);
        check("halted_ignores_pause", int'(state), 3);
        check("halted_no_ticks", n_ticks, t_before);
        step(cur_st, 1'b0, cur_sd, cur_lvl, 1'b1, 1'b1);
        check("restart_wins", int'(state), 0);
        cur_go = 1'b0;
        idle(1);
        check("restart_to_run", int'(state), 1);

        // Async reset between edges.
        idle(25);
        #1;
        rst = 1'b0;
        #1;
        check("async_tick", int'(drop_tick), 0);
        check("async_running", int'(running), 0);
        check("async_paused", int'(paused), 0);
        check("async_state", int'(state), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        m_mode = 0; m_since = 0;
        cur_st = 1'b0;

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) cur_st = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) cur_sd = ~cur_sd;
            if ($urandom_range(0, 31) == 0) cur_lvl = int'($urandom_range(0, 15));
            cur_go = ($urandom_range(0, 59) == 0);
            step(cur_st, ($urandom_range(0, 15) == 0), cur_sd, cur_lvl, cur_go,
                 ($urandom_range(0, 99) == 0));
        end

        check("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
